alu_arbiter: RTL and testbench

Shares one 32-bit ALU between two independent requesters (requester 0 and requester 1) using valid/ready handshakes. The block grants a request, latches its operands and opcode, and evaluates the ALU on the registered operands. It then returns the registered result, the NZVC flags and an error flag, tagged with the requester id, on a single response channel. It sits between the two operand-issuing datapath stages and the ALU. It holds one operation in flight at a time.

---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester valid/ready arbiter in front of one 32-bit ALU, one operation in flight.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_n,
    output logic        rsp_z,
    output logic        rsp_v,
    output logic        rsp_c,
    output logic        rsp_error
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_SLL = 4'b0001,
                           OP_SGT = 4'b0010, OP_UGT = 4'b0011, OP_XOR = 4'b0100,
                           OP_SRL = 4'b0101, OP_SRA = 4'b1101, OP_OR  = 4'b0110,
                           OP_AND = 4'b0111;

    state_t      state, state_nxt;
    logic        prio;
    logic        grant_id;
    logic        accept;
    logic        rsp_done;
    logic [31:0] op_a, op_b;
    logic [3:0]  op_code;
    logic        op_id;
    logic [31:0] alu_result;
    logic        alu_v, alu_c, alu_error;
    logic [32:0] wide;

    // Tie goes to the priority holder; otherwise the lone valid requester wins.
    assign grant_id   = req1_valid & (~req0_valid | prio);
    // NOTE: readies are combinational, so they are gated by rst explicitly; the state
    // register alone would let them rise during the reset cycles.
    assign req0_ready = ~rst & (state == IDLE) & req0_valid & ~grant_id;
    assign req1_ready = ~rst & (state == IDLE) & req1_valid &  grant_id;
    assign accept     = req0_ready | req1_ready;
    assign rsp_valid  = ~rst & (state == RESP);
    assign rsp_done   = rsp_valid & rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign prio = 1'b0;
`else
    always_ff @(posedge clk) begin
        if (rst)           prio <= PRIO_INIT;
        else if (rsp_done) prio <= ~rsp_id;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = EXEC;
            EXEC:                  state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            op_code <= '0;
            op_id   <= 1'b0;
        end else if (accept) begin
            op_a    <= grant_id ? req1_a  : req0_a;
            op_b    <= grant_id ? req1_b  : req0_b;
            op_code <= grant_id ? req1_op : req0_op;
            op_id   <= grant_id;
        end
    end

    always_comb begin
        alu_result = '0;
        alu_v      = 1'b0;
        alu_c      = 1'b0;
        alu_error  = 1'b0;
        wide       = '0;
        case (op_code)
            OP_ADD: begin
                wide       = {1'b0, op_a} + {1'b0, op_b};
                alu_result = wide[31:0];
                alu_c      = wide[32];
                alu_v      = (op_a[31] == op_b[31]) && (wide[31] != op_a[31]);
            end
            OP_SUB: begin
                wide       = {1'b0, op_a} - {1'b0, op_b};
                alu_result = wide[31:0];
                alu_c      = wide[32];
                alu_v      = (op_a[31] != op_b[31]) && (wide[31] != op_a[31]);
            end
            OP_SLL:  alu_result = op_a << op_b[4:0];
            OP_SGT:  alu_result = {31'd0, $signed(op_a) > $signed(op_b)};
            OP_UGT:  alu_result = {31'd0, op_a > op_b};
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_SRL:  alu_result = op_a >> op_b[4:0];
            OP_SRA:  alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
            OP_OR:   alu_result = op_a | op_b;
            OP_AND:  alu_result = op_a & op_b;
            default: alu_error  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_n      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_c      <= 1'b0;
            rsp_error  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id     <= op_id;
            rsp_result <= alu_result;
            rsp_n      <= alu_result[31];
            rsp_z      <= (alu_result == '0);
            rsp_v      <= alu_v;
            rsp_c      <= alu_c;
            rsp_error  <= alu_error;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a behavioural ALU/arbiter model.
// Honors ALU_ARB_FIXED_PRIO_EN the same way the design does.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_n, rsp_z, rsp_v, rsp_c, rsp_error;

    int tests_run = 0;
    int tests_failed = 0;
    bit model_prio = 1'b0;

    typedef struct {
        logic [31:0] r;
        logic n, z, v, c, e;
    } rsp_t;

    alu_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_n(rsp_n), .rsp_z(rsp_z),
        .rsp_v(rsp_v), .rsp_c(rsp_c), .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit out_of_range(input longint s);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Expected ALU behaviour derived from integer arithmetic on the operands.
    function automatic rsp_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        rsp_t   x;
        longint sa, sb;
        logic [63:0] u;
        x  = '{r: 32'd0, n: 1'b0, z: 1'b0, v: 1'b0, c: 1'b0, e: 1'b0};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'b0000: begin
                x.r = a + b;
                u   = {32'd0, a} + {32'd0, b};
                x.c = (u > 64'hFFFF_FFFF);
                x.v = out_of_range(sa + sb);
            end
            4'b1000: begin
                x.r = a - b;
                x.c = (a < b);
                x.v = out_of_range(sa - sb);
            end
            4'b0001: x.r = a << b[4:0];
            4'b0010: x.r = (sa > sb) ? 32'd1 : 32'd0;
            4'b0011: x.r = (a > b) ? 32'd1 : 32'd0;
            4'b0100: x.r = a ^ b;
            4'b0101: x.r = a >> b[4:0];
            4'b1101: x.r = 32'(sa >>> b[4:0]);
            4'b0110: x.r = a | b;
            4'b0111: x.r = a & b;
            default: x.e = 1'b1;
        endcase
        x.n = x.r[31];
        x.z = (x.r == 32'd0);
        return x;
    endfunction

    function automatic bit pick_winner(input bit v0, input bit v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return !v0;
`else
        return (v0 && v1) ? model_prio : v1;
`endif
    endfunction

    task automatic check_rsp(input string tag, input bit id, input rsp_t e);
        check({tag, ".valid"},  rsp_valid,  1);
        check({tag, ".id"},     rsp_id,     id);
        check({tag, ".result"}, rsp_result, e.r);
        check({tag, ".flags"},  {rsp_n, rsp_z, rsp_v, rsp_c, rsp_error},
                                {e.n, e.z, e.v, e.c, e.e});
        check({tag, ".rdy"},    {req0_ready, req1_ready}, 0);
    endtask

    task automatic scramble_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom);
    endtask

    // Full transaction from IDLE: accept, EXEC, RESP held for 'hold' cycles, handshake.
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                           input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                           input int hold, input string tag);
        bit   w;
        rsp_t e;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready  = 1'b0;
        w = pick_winner(v0, v1);
        e = w ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
        #1;
        check({tag, ".accept"}, {req0_ready, req1_ready}, w ? 2'b01 : 2'b10);
        tick();
        scramble_inputs();
        #1;
        check({tag, ".exec"}, {rsp_valid, req0_ready, req1_ready}, 0);
        tick();
        check_rsp({tag, ".resp"}, w, e);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_rsp({tag, ".hold"}, w, e);
        end
        rsp_ready = 1'b1;
        #1;
        check({tag, ".hs_rdy"}, {req0_ready, req1_ready}, 0);
        tick();
        rsp_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check({tag, ".done"}, rsp_valid, 0);
        model_prio = ~w;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        #1;
        check("rst.pre", {rsp_valid, req0_ready, req1_ready}, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst.out", {rsp_valid, req0_ready, req1_ready, rsp_id, rsp_n, rsp_z, rsp_v, rsp_c, rsp_error}, 0);
            check("rst.result", rsp_result, 0);
        end
        rst = 1'b0;
        model_prio = 1'b0;

        // First accept immediately after reset; ADD overflow wraps to zero.
        run_txn(1, 1, 32'hFFFF_FFFF, 32'h1, 4'b0000, 32'h5, 32'h3, 4'b0111, 0, "add_ovf");
        check("add_ovf.const", {rsp_id, rsp_result}, 33'h0);
        // Both valid again: round robin now favours req1 (req1 SUB overflow).
        run_txn(1, 1, 32'h1234, 32'h4321, 4'b0110, 32'h8000_0000, 32'h1, 4'b1000, 0, "sub_ovf");
        run_txn(1, 0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 4'b0100, 0, 0, 0, 5, "bkpr");
        run_txn(0, 1, 0, 0, 0, 32'hABCD, 32'h1, 4'b1111, 1, "undef");

        // Reset during EXEC discards the operation.
        req0_valid = 1'b1; req0_a = 32'h7; req0_b = 32'h9; req0_op = 4'b0000;
        req1_valid = 1'b0;
        #1;
        check("rstmid.accept", {req0_ready, req1_ready}, 2'b10);
        tick();
        rst = 1'b1;
        req0_valid = 1'b0;
        tick();
        check("rstmid.novalid", {rsp_valid, rsp_result}, 0);
        rst = 1'b0;
        model_prio = 1'b0;
        tick();
        check("rstmid.idle", rsp_valid, 0);

        for (int n = 0; n < 200; n++) begin
            bit [1:0]    vv;
            logic [31:0] a0, b0, a1, b1;
            vv = 2'($urandom_range(1, 3));
            a0 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            a1 = $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            run_txn(vv[0], vv[1], a0, b0, 4'($urandom), a1, b1, 4'($urandom),
                    $urandom_range(0, 3), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
